// File: rtl/result_tx_scheduler_pkg.sv
// result_tx_scheduler shared types and constants.
// RESULT_TX_SYNC_EN adds a sync byte and checksum to each frame.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

package result_tx_scheduler_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARM  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

`ifdef RESULT_TX_SYNC_EN
  localparam int FRAME_EXTRA = 2;
`else
  localparam int FRAME_EXTRA = 0;
`endif

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/result_tx_scheduler_if.sv
// Handshake bundle between the scheduler, the
// hidden layer outputs and uart_tx.
interface result_tx_scheduler_if #(
  parameter int NUM_NEURONS = 4,
  parameter int DATA_WIDTH  = `DATA_WIDTH
);
  logic                              capture;
  logic [NUM_NEURONS*DATA_WIDTH-1:0] n_in;
  logic                              tx_active;
  logic                              tx_done;
  logic                              clr_overrun;
  logic                              tx_start;
  logic [7:0]                        tx_data;
  logic                              busy;
  logic                              frame_done;
  logic                              overrun;

  modport master (
    input  capture, n_in, tx_active,
    input  tx_done, clr_overrun,
    output tx_start, tx_data, busy,
    output frame_done, overrun
  );

  modport slave (
    output capture, n_in, tx_active,
    output tx_done, clr_overrun,
    input  tx_start, tx_data, busy,
    input  frame_done, overrun
  );
endinterface

// File: rtl/result_tx_scheduler_tx_byte_selector.sv
// Picks the frame byte at i_byte_idx from the snapshot.
// RESULT_TX_SYNC_EN adds sync (idx 0) and checksum (last).
module result_tx_scheduler_tx_byte_selector
  import result_tx_scheduler_pkg::*;
#(
  parameter int NUM_NEURONS = 4,
  parameter int DATA_WIDTH  = `DATA_WIDTH,
  parameter int IDX_W       = 2
) (
  input  logic [NUM_NEURONS*DATA_WIDTH-1:0] i_snapshot,
  input  logic [IDX_W-1:0]                  i_byte_idx,
  output logic [7:0]                        o_byte
);
  localparam int NB = NUM_NEURONS * (DATA_WIDTH / 8);

  logic [7:0] w_byte;

`ifdef RESULT_TX_SYNC_EN
  logic [7:0] w_sum;

  // sync, payload or mod-256 payload checksum
  always_comb begin
    w_sum  = '0;
    w_byte = '0;
    for (int k = 0; k < NB; k++)
      w_sum = w_sum + i_snapshot[k*8 +: 8];
    if (i_byte_idx == '0)
      w_byte = SYNC_BYTE;
    else if (i_byte_idx == IDX_W'(NB + 1))
      w_byte = w_sum;
    else
      for (int k = 0; k < NB; k++)
        if (i_byte_idx == IDX_W'(k + 1))
          w_byte = i_snapshot[k*8 +: 8];
  end
`else
  // neuron-major, LSB-first payload byte
  always_comb begin
    w_byte = '0;
    for (int k = 0; k < NB; k++)
      if (i_byte_idx == IDX_W'(k))
        w_byte = i_snapshot[k*8 +: 8];
  end
`endif

  assign o_byte = w_byte;
endmodule

// File: rtl/result_tx_scheduler.sv
// Snapshots neuron outputs and feeds them to uart_tx.
// RESULT_TX_SYNC_EN frames them with sync and checksum.
module result_tx_scheduler
  import result_tx_scheduler_pkg::*;
#(
  parameter int NUM_NEURONS = 4,
  parameter int DATA_WIDTH  = `DATA_WIDTH
) (
  input logic                   clk,
  input logic                   reset,
  result_tx_scheduler_if.master bus
);
  localparam int BYTES_PER_WORD = DATA_WIDTH / 8;
  localparam int NB = NUM_NEURONS * BYTES_PER_WORD;
  localparam int FRAME_LEN = NB + FRAME_EXTRA;
  localparam int IDX_W = idx_width(FRAME_LEN);
  localparam int SW = NUM_NEURONS * DATA_WIDTH;
  localparam logic [IDX_W-1:0] LAST_IDX =
    IDX_W'(FRAME_LEN - 1);

  state_t           r_state;
  logic [IDX_W-1:0] r_byte_idx;
  logic [SW-1:0]    r_snapshot;
  logic             r_tx_start;
  logic [7:0]       r_tx_data;
  logic             r_busy;
  logic             r_frame_done;
  logic             r_overrun;
  logic [7:0]       w_byte;

  result_tx_scheduler_tx_byte_selector #(
    .NUM_NEURONS (NUM_NEURONS),
    .DATA_WIDTH  (DATA_WIDTH),
    .IDX_W       (IDX_W)
  ) u_sel (
    .i_snapshot (r_snapshot),
    .i_byte_idx (r_byte_idx),
    .o_byte     (w_byte)
  );

  // frame FSM with registered handshake outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_byte_idx   <= '0;
      r_snapshot   <= '0;
      r_tx_start   <= 1'b0;
      r_tx_data    <= '0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_tx_start   <= 1'b0;
      r_frame_done <= 1'b0;
      if (bus.capture && r_state != S_IDLE)
        r_overrun <= 1'b1;
      else if (bus.clr_overrun)
        r_overrun <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (bus.capture) begin
            r_snapshot <= bus.n_in;
            r_byte_idx <= '0;
            r_busy     <= 1'b1;
            r_state    <= S_ARM;
          end
        end
        S_ARM: begin
          if (!bus.tx_active) begin
            r_tx_start <= 1'b1;
            r_tx_data  <= w_byte;
            r_state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.tx_done) begin
            if (r_byte_idx == LAST_IDX) begin
              r_frame_done <= 1'b1;
              r_state      <= S_DONE;
            end else begin
              r_byte_idx <= r_byte_idx + IDX_W'(1);
              r_state    <= S_ARM;
            end
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.tx_start   = r_tx_start;
  assign bus.tx_data    = r_tx_data;
  assign bus.busy       = r_busy;
  assign bus.frame_done = r_frame_done;
  assign bus.overrun    = r_overrun;
endmodule
